// File: rtl/mux_test_sequencer_if.sv
// Stimulus/response bundle between the sequencer and the 4:1 mux under test.
// The sequencer drives selects and data; the mux returns its two outputs.
interface mux_test_sequencer_if;
  logic [3:0] stim_i;
  logic [1:0] stim_s;
  logic       gf_out;
  logic       bfg_out;

  modport master (output stim_i, output stim_s, input gf_out, input bfg_out);
  modport slave  (input stim_i, input stim_s, output gf_out, output bfg_out);
endinterface

// File: rtl/mux_test_sequencer.sv
// Sweeps all 64 {s1,s0,i3..i0} vectors through the mux under test, checks both
// mux outputs against the golden function and each other, and keeps error stats.
module mux_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned CNT_W         = 8
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 loop_en,
  mux_test_sequencer_if.master mux,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     gf_err_cnt,
  output logic [CNT_W-1:0]     bfg_err_cnt,
  output logic [CNT_W-1:0]     diff_cnt,
  output logic [5:0]           first_fail_vec,
  output logic                 first_fail_valid
);
  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [5:0]       vec_q, vec_d;
  logic [7:0]       settle_q, settle_d;
  logic [1:0]       gf_sync_q, gf_sync_d;
  logic [1:0]       bfg_sync_q, bfg_sync_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CNT_W-1:0] gf_cnt_q, gf_cnt_d;
  logic [CNT_W-1:0] bfg_cnt_q, bfg_cnt_d;
  logic [CNT_W-1:0] diff_cnt_q, diff_cnt_d;
  logic [5:0]       ff_vec_q, ff_vec_d;
  logic             ff_valid_q, ff_valid_d;

  logic [3:0] data_bits;
  logic       exp_bit, gf_bad, bfg_bad, out_diff;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c, input logic hit);
    return (hit && (c != '1)) ? c + CNT_W'(1) : c;
  endfunction

  always_comb begin
    data_bits = vec_q[3:0];
    exp_bit   = data_bits[vec_q[5:4]];
    gf_bad    = gf_sync_q[1] != exp_bit;
    bfg_bad   = bfg_sync_q[1] != exp_bit;
    out_diff  = gf_sync_q[1] != bfg_sync_q[1];
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    settle_d   = settle_q;
    gf_sync_d  = {gf_sync_q[0], mux.gf_out};
    bfg_sync_d = {bfg_sync_q[0], mux.bfg_out};
    busy_d     = busy_q;
    done_d     = done_q;
    pass_d     = pass_q;
    gf_cnt_d   = gf_cnt_q;
    bfg_cnt_d  = bfg_cnt_q;
    diff_cnt_d = diff_cnt_q;
    ff_vec_d   = ff_vec_q;
    ff_valid_d = ff_valid_q;

    // Abort is evaluated first so a coincident start is dropped and a
    // SAMPLE-cycle abort leaves the counters untouched.
    if (abort) begin
      if (state_q != IDLE) begin
        state_d = IDLE;
        vec_d   = '0;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pass_d  = 1'b0;
      end
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start) begin
            state_d    = DRIVE;
            vec_d      = '0;
            settle_d   = SETTLE_INIT;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            pass_d     = 1'b0;
            gf_cnt_d   = '0;
            bfg_cnt_d  = '0;
            diff_cnt_d = '0;
            ff_valid_d = 1'b0;
          end
        end
        DRIVE: begin
          if (settle_q == 8'd0) state_d = SAMPLE;
          else                  settle_d = settle_q - 8'd1;
        end
        SAMPLE: begin
          gf_cnt_d   = sat_inc(gf_cnt_q, gf_bad);
          bfg_cnt_d  = sat_inc(bfg_cnt_q, bfg_bad);
          diff_cnt_d = sat_inc(diff_cnt_q, out_diff);
          if ((gf_bad || bfg_bad) && !ff_valid_q) begin
            ff_vec_d   = vec_q;
            ff_valid_d = 1'b1;
          end
          if (vec_q != 6'd63 || loop_en) begin
            vec_d    = vec_q + 6'd1;
            settle_d = SETTLE_INIT;
            state_d  = DRIVE;
          end else begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (gf_cnt_d == '0) && (bfg_cnt_d == '0) && (diff_cnt_d == '0);
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      settle_q   <= '0;
      gf_sync_q  <= '0;
      bfg_sync_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      gf_cnt_q   <= '0;
      bfg_cnt_q  <= '0;
      diff_cnt_q <= '0;
      ff_vec_q   <= '0;
      ff_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      settle_q   <= settle_d;
      gf_sync_q  <= gf_sync_d;
      bfg_sync_q <= bfg_sync_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      gf_cnt_q   <= gf_cnt_d;
      bfg_cnt_q  <= bfg_cnt_d;
      diff_cnt_q <= diff_cnt_d;
      ff_vec_q   <= ff_vec_d;
      ff_valid_q <= ff_valid_d;
    end
  end

  assign mux.stim_i       = vec_q[3:0];
  assign mux.stim_s       = vec_q[5:4];
  assign busy             = busy_q;
  assign done             = done_q;
  assign pass             = pass_q;
  assign gf_err_cnt       = gf_cnt_q;
  assign bfg_err_cnt      = bfg_cnt_q;
  assign diff_cnt         = diff_cnt_q;
  assign first_fail_vec   = ff_vec_q;
  assign first_fail_valid = ff_valid_q;
endmodule

// File: tb/tb_mux_test_sequencer.sv
// Scoreboard bench: two sequencers (CNT_W=8 and CNT_W=6) each driving a
// behavioural mux with injectable per-vector faults.
module tb_mux_test_sequencer;
  localparam int S     = 8;
  localparam int SWEEP = 64 * (S + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start_a = 0, abort_a = 0, loop_a = 0;
  logic start_b = 0, abort_b = 0, loop_b = 0;

  mux_test_sequencer_if ifa ();
  mux_test_sequencer_if ifb ();

  logic       busy_a, done_a, pass_a, ffval_a;
  logic [7:0] gfc_a, bfc_a, dfc_a;
  logic [5:0] ffv_a;
  logic       busy_b, done_b, pass_b, ffval_b;
  logic [5:0] gfc_b, bfc_b, dfc_b;
  logic [5:0] ffv_b;

  logic [63:0] gf_mask = '0, bfg_mask = '0, stuck_mask;
  logic [5:0]  stim_a, stim_b;

  function automatic logic ideal(input logic [5:0] v);
    return v[v[5:4]];
  endfunction

  assign stim_a      = {ifa.stim_s, ifa.stim_i};
  assign stim_b      = {ifb.stim_s, ifb.stim_i};
  assign ifa.gf_out  = ideal(stim_a) ^ gf_mask[stim_a];
  assign ifa.bfg_out = ideal(stim_a) ^ bfg_mask[stim_a];
  assign ifb.gf_out  = ideal(stim_b);
  assign ifb.bfg_out = 1'b0;

  mux_test_sequencer #(.SETTLE_CYCLES(S), .CNT_W(8)) dut_a (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_a), .abort(abort_a), .loop_en(loop_a),
    .mux(ifa), .busy(busy_a), .done(done_a), .pass(pass_a),
    .gf_err_cnt(gfc_a), .bfg_err_cnt(bfc_a), .diff_cnt(dfc_a),
    .first_fail_vec(ffv_a), .first_fail_valid(ffval_a));

  mux_test_sequencer #(.SETTLE_CYCLES(S), .CNT_W(6)) dut_b (
    .wb_clk_i(clk), .wb_rst_i(rst), .start(start_b), .abort(abort_b), .loop_en(loop_b),
    .mux(ifb), .busy(busy_b), .done(done_b), .pass(pass_b),
    .gf_err_cnt(gfc_b), .bfg_err_cnt(bfc_b), .diff_cnt(dfc_b),
    .first_fail_vec(ffv_b), .first_fail_valid(ffval_b));

  typedef struct {
    int         gf, bfg, diff, cycles;
    logic [5:0] ffv;
    logic       ffval, pass;
  } exp_t;

  exp_t q_a[$], q_b[$];
  int checks = 0, fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input int exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Error masks mark vectors where an output is wrong; counts are popcounts
  // over the first nvec vectors, scaled by sweeps and clipped at the counter max.
  function automatic exp_t model(input logic [63:0] gm, input logic [63:0] bm,
                                 input int sweeps, input int nvec, input int maxc);
    exp_t e;
    int g = 0, b = 0, d = 0;
    e.ffval = 1'b0;
    e.ffv   = '0;
    for (int v = 0; v < nvec; v++) begin
      if (gm[v]) g++;
      if (bm[v]) b++;
      if (gm[v] != bm[v]) d++;
      if ((gm[v] || bm[v]) && !e.ffval) begin
        e.ffval = 1'b1;
        e.ffv   = 6'(v);
      end
    end
    e.gf     = (g * sweeps > maxc) ? maxc : g * sweeps;
    e.bfg    = (b * sweeps > maxc) ? maxc : b * sweeps;
    e.diff   = (d * sweeps > maxc) ? maxc : d * sweeps;
    e.pass   = (e.gf == 0) && (e.bfg == 0) && (e.diff == 0);
    e.cycles = sweeps * SWEEP;
    return e;
  endfunction

  task automatic cmp_rec(input string t, input exp_t e, input int cyc, input logic bsy,
                         input logic ps, input int g, input int b, input int d,
                         input logic [5:0] fv, input logic fval);
    chk({t, "_busy_cycles"}, cyc, e.cycles);
    chk({t, "_busy_at_done"}, bsy, 0);
    chk({t, "_pass"}, ps, int'(e.pass));
    chk({t, "_gf_err_cnt"}, g, e.gf);
    chk({t, "_bfg_err_cnt"}, b, e.bfg);
    chk({t, "_diff_cnt"}, d, e.diff);
    chk({t, "_ff_valid"}, fval, int'(e.ffval));
    if (e.ffval) chk({t, "_ff_vec"}, fv, int'(e.ffv));
  endtask

  // Monitor: stim walk order for A, busy length and end-of-sweep results for A and B.
  initial begin
    logic pb_a = 0, pd_a = 0, pb_b = 0, pd_b = 0;
    logic [5:0] ps_a = '0;
    int cyc_a = 0, cyc_b = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (busy_a && !pb_a) begin
        cyc_a = 0;
        chk("stim_first", stim_a, 0);
      end else if (busy_a && stim_a != ps_a) begin
        chk("stim_step", stim_a, (int'(ps_a) + 1) % 64);
      end
      if (busy_a) cyc_a++;
      if (busy_b && !pb_b) cyc_b = 0;
      if (busy_b) cyc_b++;
      if (done_a && !pd_a) begin
        if (q_a.size() == 0) chk("unexpected_done_a", 1, 0);
        else begin
          e = q_a.pop_front();
          cmp_rec("A", e, cyc_a, busy_a, pass_a, gfc_a, bfc_a, dfc_a, ffv_a, ffval_a);
        end
      end
      if (done_b && !pd_b) begin
        if (q_b.size() == 0) chk("unexpected_done_b", 1, 0);
        else begin
          e = q_b.pop_front();
          cmp_rec("B", e, cyc_b, busy_b, pass_b, gfc_b, bfc_b, dfc_b, ffv_b, ffval_b);
        end
      end
      pb_a = busy_a; pd_a = done_a; ps_a = stim_a;
      pb_b = busy_b; pd_b = done_b;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start_a();
    start_a = 1'b1;
    tick(1);
    start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int budget);
    int n = 0;
    while (!done_a && n < budget) begin tick(1); n++; end
    if (!done_a) chk("timeout_done_a", 0, 1);
  endtask

  task automatic wait_stim_a(input int v);
    int n = 0;
    while (stim_a != 6'(v) && n < SWEEP) begin tick(1); n++; end
    if (stim_a != 6'(v)) chk("timeout_stim_a", stim_a, v);
  endtask

  task automatic run_a(input logic [63:0] gm, input logic [63:0] bm, input int sweeps);
    gf_mask  = gm;
    bfg_mask = bm;
    q_a.push_back(model(gm, bm, sweeps, 64, 255));
    loop_a = (sweeps > 1);
    pulse_start_a();
    if (sweeps > 1) begin
      tick((sweeps - 1) * SWEEP + 100);
      loop_a = 1'b0;
    end
    wait_done_a(SWEEP + 50);
    tick(2);
  endtask

  task automatic check_all_zero_a(input string t);
    chk({t, "_busy"}, busy_a, 0);
    chk({t, "_done"}, done_a, 0);
    chk({t, "_pass"}, pass_a, 0);
    chk({t, "_stim"}, stim_a, 0);
    chk({t, "_gf_err_cnt"}, gfc_a, 0);
    chk({t, "_bfg_err_cnt"}, bfc_a, 0);
    chk({t, "_diff_cnt"}, dfc_a, 0);
    chk({t, "_ff_vec"}, ffv_a, 0);
    chk({t, "_ff_valid"}, ffval_a, 0);
  endtask

  initial begin
    exp_t e;
    int n;
    for (int v = 0; v < 64; v++) stuck_mask[v] = ideal(6'(v));

    tick(3);
    check_all_zero_a("reset");
    rst = 1'b0;
    tick(2);

    run_a('0, '0, 1);                 // ideal mux
    run_a('0, stuck_mask, 1);         // bfg stuck at 0
    run_a('1, '0, 1);                 // gf inverted
    for (int r = 0; r < 4; r++)
      run_a({$urandom, $urandom} & {$urandom, $urandom}, {$urandom, $urandom} & {$urandom, $urandom}, 1);
    run_a({$urandom, $urandom}, {$urandom, $urandom}, 2);

    // start while busy is ignored: busy length and results stay those of one sweep
    gf_mask  = {$urandom, $urandom} & {$urandom, $urandom};
    bfg_mask = '0;
    q_a.push_back(model(gf_mask, bfg_mask, 1, 64, 255));
    pulse_start_a();
    tick(200);
    pulse_start_a();
    wait_done_a(SWEEP + 50);
    tick(2);

    // abort at vec 20: counters hold the first 20 samples
    gf_mask  = '0;
    bfg_mask = stuck_mask;
    pulse_start_a();
    wait_stim_a(20);
    abort_a = 1'b1;
    tick(1);
    abort_a = 1'b0;
    e = model(gf_mask, bfg_mask, 1, 20, 255);
    chk("abort_busy", busy_a, 0);
    chk("abort_done", done_a, 0);
    chk("abort_pass", pass_a, 0);
    chk("abort_stim", stim_a, 0);
    tick(5);
    chk("abort_gf_err_cnt", gfc_a, e.gf);
    chk("abort_bfg_err_cnt", bfc_a, e.bfg);
    chk("abort_diff_cnt", dfc_a, e.diff);
    chk("abort_ff_vec", ffv_a, int'(e.ffv));
    chk("abort_ff_valid", ffval_a, int'(e.ffval));
    chk("abort_stays_idle", busy_a, 0);
    run_a(gf_mask, bfg_mask, 1);      // fresh start clears counters

    // start and abort together during a run
    pulse_start_a();
    tick(100);
    start_a = 1'b1;
    abort_a = 1'b1;
    tick(1);
    start_a = 1'b0;
    abort_a = 1'b0;
    chk("startabort_busy", busy_a, 0);
    chk("startabort_done", done_a, 0);
    chk("startabort_stim", stim_a, 0);
    tick(10);
    chk("startabort_stays_idle", busy_a, 0);

    // reset at vec 40
    pulse_start_a();
    wait_stim_a(40);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_all_zero_a("midreset");
    tick(20);
    check_all_zero_a("midreset_idle");

    // CNT_W=6 instance: three looping sweeps with bfg stuck at 0 saturate at 63
    q_b.push_back(model('0, stuck_mask, 3, 64, 63));
    loop_b  = 1'b1;
    start_b = 1'b1;
    tick(1);
    start_b = 1'b0;
    tick(2 * SWEEP + 100);
    loop_b = 1'b0;
    n = 0;
    while (!done_b && n < SWEEP + 50) begin tick(1); n++; end
    if (!done_b) chk("timeout_done_b", 0, 1);
    tick(2);

    chk("scoreboard_drained", q_a.size() + q_b.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/mux_test_sequencer.md
Name: mux_test_sequencer

Overview:
- Stimulus generator and checker wrapped around the 4:1 mux comparison block, instantiated beside it in user_project_wrapper.
- Drives all 64 combinations of {s1,s0,i3..i0} into the mux under test and samples both outputs (gf_out, bfg_out) after a programmable settle time.
- Checks each output against the golden mux function and against each other.
- Accumulates error counts and records the first failing vector for readout over LA/IO.

Parameters:
- SETTLE_CYCLES, 8, cycles each vector is held before sampling; legal range 3..255.
- CNT_W, 8, width of each error counter.

Ports:
- wb_clk_i  in  1  sole clock.
- wb_rst_i  in  1  synchronous, active-high reset.
- start  in  1  single-cycle run request.
- abort  in  1  single-cycle run cancel.
- loop_en  in  1  sweep continuously while high.
- stim_i  out  4  data inputs to the mux under test (i3..i0).
- stim_s  out  2  select inputs to the mux under test (s1,s0).
- gf_out  in  1  standard-cell mux output; asynchronous to wb_clk_i.
- bfg_out  in  1  generated mux output; asynchronous to wb_clk_i.
- busy  out  1  run in progress.
- done  out  1  sweep completed; held until next accepted start.
- pass  out  1  done and all counters zero.
- gf_err_cnt  out  CNT_W  vectors where gf_out != expected.
- bfg_err_cnt  out  CNT_W  vectors where bfg_out != expected.
- diff_cnt  out  CNT_W  vectors where gf_out != bfg_out.
- first_fail_vec  out  6  {s1,s0,i3,i2,i1,i0} of first gf or bfg error in the run.
- first_fail_valid  out  1  first_fail_vec holds a captured vector.

Behaviour:
- Reset: the following are all 0.
  - All outputs, including stim_i, stim_s and the counters.
  - The vector index.
  - The synchronizer flops.
  - State = IDLE.
- Vector index vec[5:0]: stim_i = vec[3:0], stim_s = vec[5:4], both driven from flops.
- Expected value = stim_i[stim_s].
- gf_out and bfg_out each pass through a 2-flop synchronizer (latency 2) before comparison.
- States:
  - IDLE / DONE, start=1: clear counters, first_fail_valid, done and pass; vec=0; settle counter = SETTLE_CYCLES-1. Next state DRIVE, busy=1 on the next cycle.
  - DRIVE: decrement settle counter each cycle. At 0, go to SAMPLE.
  - SAMPLE (1 cycle):
    - Compare the synchronized outputs with the expected value and with each other.
    - Increment each counter whose condition fails; counters saturate at 2^CNT_W-1.
    - If gf or bfg is in error and first_fail_valid=0: capture vec, set first_fail_valid.
    - vec<63: vec++, reload settle counter, go to DRIVE.
    - vec==63 and loop_en=0: go to DONE; busy=0, done=1, pass = all three counters zero, including this sample's update.
    - vec==63 and loop_en=1: vec wraps to 0, go to DRIVE. Counters and first_fail keep accumulating; done stays 0.
- Cycles per vector = SETTLE_CYCLES+1. Per sweep = 64*(SETTLE_CYCLES+1), i.e. 576 at default.
- done asserts on the cycle after the final SAMPLE.
- abort in any state except IDLE: next cycle state=IDLE, busy=0, done=0, pass=0, stim_i and stim_s = 0. Counters and first_fail are retained for readout.
- start and abort in the same cycle: abort wins, start is dropped.
- start while busy: ignored.
- loop_en is sampled only at vec==63 in SAMPLE.
- wb_rst_i mid-run: full reset on the next edge, identical to power-on reset; overrides start and abort.
- No combinational path from any input to any output.

Test Plan:
- Ideal mux model (zero delay), SETTLE_CYCLES=8; pulse start -> busy for 576 cycles, then done=1, pass=1, all counters 0, first_fail_valid=0; stim walks 0..63 in order.
- bfg_out stuck at 0, gf correct -> bfg_err_cnt=32, diff_cnt=32, gf_err_cnt=0, first_fail_vec=6'd1, first_fail_valid=1, pass=0.
- gf_out inverted, bfg correct -> gf_err_cnt=64, diff_cnt=64, bfg_err_cnt=0, first_fail_vec=0, pass=0.
- CNT_W=6, bfg stuck at 0, loop_en=1 for 3 sweeps then dropped -> bfg_err_cnt saturates at 63 (not 96 mod 64); done after the 3rd sweep (1728 cycles).
- abort at vec=20 -> IDLE next cycle, stim=0, done=0, counters hold their values. A new start then clears the counters and runs the full sweep.
- start while busy -> no effect. start+abort in the same cycle during a run -> IDLE. wb_rst_i asserted at vec=40 -> all outputs 0 the next cycle, stays IDLE with no start.
